// File: rtl/irq_injector_pkg.sv
// Shared types and helpers for the button-to-interrupt injector.
// Holds the addi encoding, field widths and the issue FSM state type.
package irq_pkg;

  localparam int OPC_W = 5;
  localparam int REG_W = 5;
  localparam int IMM_W = 17;

  localparam logic [OPC_W-1:0] OP_ADDI = 5'b00101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_e;

  // addi rd, $r0, code
  function automatic logic [31:0] build_instr(input logic [REG_W-1:0] rd,
                                              input logic [IMM_W-1:0] code);
    return {OP_ADDI, rd, {REG_W{1'b0}}, code};
  endfunction

endpackage

// File: rtl/irq_injector_if.sv
// CPU-facing side of the injector: the injected instruction word plus
// queue occupancy and activity status.
interface irq_injector_if #(
  parameter int FIFO_DEPTH = 4
);
  logic [31:0]                 interrupt_instruction;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        busy;

  modport master (output interrupt_instruction, fifo_count, busy);
  modport slave  (input  interrupt_instruction, fifo_count, busy);
endinterface

// File: rtl/irq_injector_fifo.sv
// Small synchronous FIFO for button event codes; power-of-two depth so
// the pointers wrap naturally.
module irq_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_r;
  logic [AW-1:0]    rd_r;
  logic [AW:0]      cnt_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (cnt_r == (AW+1)'(DEPTH));
  assign empty     = (cnt_r == {(AW+1){1'b0}});
  assign count     = cnt_r;
  assign pop_data  = mem_r[rd_r];
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // Storage, pointers and occupancy; push and pop may coincide.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_r  <= {AW{1'b0}};
      rd_r  <= {AW{1'b0}};
      cnt_r <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_r] <= push_data;
        wr_r        <= wr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_r <= rd_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   cnt_r <= cnt_r + (AW+1)'(1);
        2'b01:   cnt_r <= cnt_r - (AW+1)'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/irq_injector.sv
// Button press -> queued addi injection into the CPU instruction stream.
// Define IRQ_INJECTOR_DEBOUNCE_EN to add per-button debounce filtering.
module irq_injector
  import irq_pkg::*;
#(
  parameter int NUM_BTN         = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int SPACING         = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int INT_REG         = 27
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] buttons,
  irq_injector_if.master     cpu
);

  localparam int CODE_W = $clog2(NUM_BTN + 1);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int GAP_W  = $clog2(SPACING);

  logic [NUM_BTN-1:0] sync1_r;
  logic [NUM_BTN-1:0] sync_r;
  logic [NUM_BTN-1:0] lvl_s;
  logic [NUM_BTN-1:0] prev_r;
  logic [NUM_BTN-1:0] edge_s;
  logic [NUM_BTN-1:0] pending_r;
  logic [NUM_BTN-1:0] low_s;
  logic [NUM_BTN-1:0] clear_s;
  logic               push_s;
  logic [CODE_W-1:0]  push_code_s;
  logic               pop_s;
  logic [CODE_W-1:0]  pop_code_s;
  logic               full_s;
  logic               empty_s;
  logic [CNT_W-1:0]   count_s;
  state_e             state_r;
  state_e             state_s;
  logic [GAP_W-1:0]   gap_r;
  logic [GAP_W-1:0]   gap_s;
  logic [31:0]        instr_r;
  logic [31:0]        instr_s;

  // Two-flop synchronizer for the asynchronous pins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_r <= {NUM_BTN{1'b0}};
      sync_r  <= {NUM_BTN{1'b0}};
    end else begin
      sync1_r <= buttons;
      sync_r  <= sync1_r;
    end
  end

`ifdef IRQ_INJECTOR_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DB_W-1:0]    db_cnt_r [NUM_BTN];
  logic [NUM_BTN-1:0] lvl_r;

  // Accept a level change only after it has persisted DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lvl_r <= {NUM_BTN{1'b0}};
      for (int i = 0; i < NUM_BTN; i++) begin
        db_cnt_r[i] <= {DB_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (sync_r[i] != lvl_r[i]) begin
          if (db_cnt_r[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            lvl_r[i]    <= sync_r[i];
            db_cnt_r[i] <= {DB_W{1'b0}};
          end else begin
            db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
          end
        end else begin
          db_cnt_r[i] <= {DB_W{1'b0}};
        end
      end
    end
  end

  assign lvl_s = lvl_r;
`else
  assign lvl_s = sync_r;
`endif

  assign edge_s = lvl_s & ~prev_r;
  // Isolate the lowest set pending bit: x & -x.
  assign low_s  = pending_r & (~pending_r + NUM_BTN'(1));

  // Arbiter: lowest pending index wins one FIFO slot per cycle.
  always_comb begin
    push_code_s = {CODE_W{1'b0}};
    for (int i = 0; i < NUM_BTN; i++) begin
      push_code_s = push_code_s | (low_s[i] ? CODE_W'(i + 1) : {CODE_W{1'b0}});
    end
    push_s  = ~full_s & (|pending_r);
    clear_s = push_s ? low_s : {NUM_BTN{1'b0}};
  end

  // Edge history and sticky pending bits; repeat edges merge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_r    <= {NUM_BTN{1'b0}};
      pending_r <= {NUM_BTN{1'b0}};
    end else begin
      prev_r    <= lvl_s;
      pending_r <= (pending_r & ~clear_s) | edge_s;
    end
  end

  irq_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_s),
    .push_data (push_code_s),
    .pop       (pop_s),
    .pop_data  (pop_code_s),
    .full      (full_s),
    .empty     (empty_s),
    .count     (count_s)
  );

  // Issue FSM state, gap counter and the registered output word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      gap_r   <= {GAP_W{1'b0}};
      instr_r <= 32'd0;
    end else begin
      state_r <= state_s;
      gap_r   <= gap_s;
      instr_r <= instr_s;
    end
  end

  // Next state; instr_s is nonzero only in the cycle that enters ISSUE.
  always_comb begin
    state_s = state_r;
    gap_s   = gap_r;
    instr_s = 32'd0;
    pop_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          instr_s = build_instr(REG_W'(INT_REG), IMM_W'(pop_code_s));
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        gap_s = GAP_W'(SPACING - 2);
        if (SPACING > 2) begin
          state_s = GAP;
        end else begin
          state_s = IDLE;
        end
      end
      GAP: begin
        gap_s = gap_r - GAP_W'(1);
        if (gap_r <= GAP_W'(1)) begin
          state_s = IDLE;
        end else begin
          state_s = GAP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign cpu.interrupt_instruction = instr_r;
  assign cpu.fifo_count            = count_s;
  assign cpu.busy                  = (|pending_r) | ~empty_s | (state_r != IDLE);

endmodule

// File: tb/tb_irq_injector.sv
// Self-checking bench for irq_injector: directed vector table, corner
// sequences and a randomized run against an event-queue reference model.
module tb_irq_injector;

  localparam int NB    = 4;
  localparam int DEPTH = 4;
  localparam int SP    = 8;
  localparam int DB    = 16;
`ifdef IRQ_INJECTOR_DEBOUNCE_EN
  localparam int EXTRA = DB;
  localparam bit DB_ON = 1'b1;
`else
  localparam int EXTRA = 0;
  localparam bit DB_ON = 1'b0;
`endif
  localparam int LAT = 5 + EXTRA;

  logic          clock;
  logic          reset;
  logic [NB-1:0] buttons;
  logic [NB-1:0] buttons2;

  irq_injector_if #(.FIFO_DEPTH(DEPTH)) bus ();
  irq_injector_if #(.FIFO_DEPTH(2))     bus2 ();

  irq_injector #(.NUM_BTN(NB), .FIFO_DEPTH(DEPTH), .SPACING(SP),
                 .DEBOUNCE_CYCLES(DB), .INT_REG(27)) dut (
    .clock(clock), .reset(reset), .buttons(buttons), .cpu(bus));

  irq_injector #(.NUM_BTN(NB), .FIFO_DEPTH(2), .SPACING(SP),
                 .DEBOUNCE_CYCLES(DB), .INT_REG(27)) dut2 (
    .clock(clock), .reset(reset), .buttons(buttons2), .cpu(bus2));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] addi_word(input int code);
    logic [16:0] c;
    c = 17'(code);
    return {5'b00101, 5'd27, 5'd0, c};
  endfunction

  // Reference model: event queue, pending set, issue time of last injection.
  logic [31:0]   mq[$];
  logic [NB-1:0] m_pend, m_lvl, m_prev;
  logic [NB-1:0] h[3];
  int            m_run[NB];
  int            m_n = 0;
  int            m_last;
  logic [31:0]   m_out;
  bit            cmp_en;

  task automatic model_reset();
    mq.delete();
    m_pend = '0; m_lvl = '0; m_prev = '0;
    for (int i = 0; i < 3; i++) h[i] = '0;
    for (int i = 0; i < NB; i++) m_run[i] = 0;
    m_last = -1000;
    m_out  = 32'd0;
  endtask

  function automatic bit m_busy();
    return (m_pend != '0) || (mq.size() != 0) || ((m_n - m_last) <= SP - 2);
  endfunction

  task automatic model_edge(input logic [NB-1:0] b);
    logic [NB-1:0] cur, edg, low;
    int pre;
    m_n++;
    cur = DB_ON ? m_lvl : h[1];
    edg = cur & ~m_prev;
    pre = mq.size();
    m_out = 32'd0;
    if (pre > 0 && (m_n - m_last) >= SP) begin
      m_out  = mq.pop_front();
      m_last = m_n;
    end
    low = '0;
    if (pre < DEPTH) begin
      for (int i = 0; i < NB; i++) begin
        if (m_pend[i] && low == '0) begin
          low[i] = 1'b1;
          mq.push_back(addi_word(i + 1));
        end
      end
    end
    m_pend = (m_pend & ~low) | edg;
    m_prev = cur;
    for (int i = 0; i < NB; i++) begin
      if (h[1][i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_lvl[i] = h[1][i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    h[2] = h[1]; h[1] = h[0]; h[0] = b;
  endtask

  task automatic step();
    @(posedge clock);
    if (!reset) model_edge(buttons);
    #1;
    if (cmp_en) begin
      check("model_out",  bus.interrupt_instruction, m_out);
      check("model_cnt",  32'(bus.fifo_count), 32'(mq.size()));
      check("model_busy", 32'(bus.busy), 32'(m_busy()));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    step(); step();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [NB-1:0]     mask;
    int                hold;
    int                n_exp;
    logic [3:0][31:0]  exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int got, nz, peak, idx;
    int tt[4];
    logic [31:0] gv[4];
    bit found;

    vecs[0].mask = 4'b0100; vecs[0].n_exp = 1; vecs[0].exp[0] = 32'h2EC0_0003;
    vecs[1].mask = 4'b1011; vecs[1].n_exp = 3; vecs[1].exp[0] = 32'h2EC0_0001;
    vecs[1].exp[1] = 32'h2EC0_0002; vecs[1].exp[2] = 32'h2EC0_0004;
    vecs[2].mask = 4'b0001; vecs[2].n_exp = 1; vecs[2].exp[0] = 32'h2EC0_0001;
    vecs[3].mask = 4'b1111; vecs[3].n_exp = 4; vecs[3].exp[0] = 32'h2EC0_0001;
    vecs[3].exp[1] = 32'h2EC0_0002; vecs[3].exp[2] = 32'h2EC0_0003;
    vecs[3].exp[3] = 32'h2EC0_0004;
    vecs[4].mask = 4'b1000; vecs[4].n_exp = 1; vecs[4].exp[0] = 32'h2EC0_0004;
    vecs[5].mask = 4'b0110; vecs[5].n_exp = 2; vecs[5].exp[0] = 32'h2EC0_0002;
    vecs[5].exp[1] = 32'h2EC0_0003;
    for (int v = 0; v < 6; v++) vecs[v].hold = 20;

    // Reset values, checked before any clock edge.
    buttons = '0; buttons2 = '0; cmp_en = 1'b1;
    reset = 1'b1;
    model_reset();
    #1;
    check("reset_out",   bus.interrupt_instruction, 32'd0);
    check("reset_count", 32'(bus.fifo_count), 32'd0);
    check("reset_busy",  32'(bus.busy), 32'd0);
    step(); step();
    reset = 1'b0;

    // Directed vector table.
    for (int v = 0; v < 6; v++) begin
      got = 0;
      buttons = vecs[v].mask;
      for (int t = 1; t <= 120; t++) begin
        step();
        if (t == vecs[v].hold) buttons = '0;
        if (bus.interrupt_instruction != 32'd0) begin
          if (got < 4) begin
            gv[got] = bus.interrupt_instruction;
            tt[got] = t;
          end
          got++;
        end
      end
      check($sformatf("vec%0d_count", v), got, vecs[v].n_exp);
      for (int k = 0; k < vecs[v].n_exp && k < got && k < 4; k++) begin
        check($sformatf("vec%0d_word%0d", v, k), gv[k], vecs[v].exp[k]);
        check($sformatf("vec%0d_time%0d", v, k), tt[k], LAT + k * SP);
      end
      check($sformatf("vec%0d_idle_busy", v), 32'(bus.busy), 32'd0);
    end

    // Depth-2 instance: four simultaneous presses, queue saturates.
    got = 0; peak = 0;
    buttons2 = 4'b1111;
    for (int t = 1; t <= 150; t++) begin
      step();
      if (t == 20) buttons2 = '0;
      if (int'(bus2.fifo_count) > peak) peak = int'(bus2.fifo_count);
      if (bus2.interrupt_instruction != 32'd0) begin
        if (got < 4) begin
          gv[got] = bus2.interrupt_instruction;
          tt[got] = t;
        end
        got++;
      end
    end
    check("d2_peak", peak, 2);
    check("d2_count", got, 4);
    for (int k = 0; k < 4 && k < got; k++) begin
      check($sformatf("d2_word%0d", k), gv[k], addi_word(k + 1));
      check($sformatf("d2_time%0d", k), tt[k], LAT + k * SP);
    end
    check("d2_idle_busy", 32'(bus2.busy), 32'd0);

`ifdef IRQ_INJECTOR_DEBOUNCE_EN
    // Short glitch must be filtered out.
    nz = 0;
    buttons = 4'b0010;
    for (int t = 1; t <= 80; t++) begin
      step();
      if (t == 10) buttons = '0;
      if (bus.interrupt_instruction != 32'd0) nz++;
    end
    check("glitch_injections", nz, 0);
`endif

    // Reset in the gap after the first injection with two events queued.
    found = 1'b0;
    buttons = 4'b0111;
    for (int t = 1; t <= 100 && !found; t++) begin
      step();
      if (bus.interrupt_instruction != 32'd0) found = 1'b1;
    end
    check("gap_first_inject_seen", 32'(found), 32'd1);
    step();
    check("gap_queued", 32'(bus.fifo_count), 32'd2);
    buttons = '0;
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    check("gap_reset_out",   bus.interrupt_instruction, 32'd0);
    check("gap_reset_count", 32'(bus.fifo_count), 32'd0);
    check("gap_reset_busy",  32'(bus.busy), 32'd0);
    step(); step();
    reset = 1'b0;
    nz = 0;
    for (int t = 0; t < 40; t++) begin
      step();
      if (bus.interrupt_instruction != 32'd0) nz++;
    end
    check("post_reset_injections", nz, 0);

    // Randomized presses, releases and re-presses against the model.
    do_reset();
    for (int t = 0; t < 1200; t++) begin
      step();
      if ($urandom_range(0, DB_ON ? 63 : 7) == 0) begin
        idx = $urandom_range(0, NB - 1);
        buttons[idx] = ~buttons[idx];
      end
    end
    buttons = '0;
    for (int t = 0; t < 80 + EXTRA; t++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_injector.md
# irq_injector

Upstream producer of the processor's `interrupt_instruction` input. Samples raw game buttons, synchronizes them, optionally debounces them, and detects press edges. It queues press events in a small FIFO and injects each event into the CPU as a single-cycle `addi` instruction. Outside those injection cycles it drives 32'b0 (nop), with enforced spacing so the pipeline absorbs one injection before the next.

## Interface
- `NUM_BTN`, 4, number of button inputs (1–8).
- `FIFO_DEPTH`, 4, queued events; must be a power of two, at least 2.
- `SPACING`, 8, total cycles from one injection to the earliest next one (≥2).
- `DEBOUNCE_CYCLES`, 16, consecutive stable cycles required to accept a level change. Used only when debounce is compiled in.
- `INT_REG`, 27, destination register written by the injected instruction.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `buttons` in NUM_BTN: raw, asynchronous, active-high pins.
- `interrupt_instruction` out 32: injected instruction, or 32'b0.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `busy` out 1: high when any pending bit is set, the FIFO is non-empty, or the FSM is not IDLE.

## Operation
- Per button, a 2-flop synchronizer produces `sync`.
- `lvl` is the debounced level, or `sync` directly when debounce is compiled out.
- `prev` holds `lvl` delayed one cycle.
- A press edge is `lvl & ~prev`.
- Each edge sets a sticky `pending[i]`.
  - A new edge while `pending[i]` is already set merges; no second event is created.
- Arbiter: each cycle, if the FIFO is not full and any pending bit is set, the lowest set index i is cleared and code i+1 is pushed.
  - Push rate is at most one per cycle.
  - When the FIFO is full, pending bits hold.
- Instruction format: {5'b00101 (addi), INT_REG[4:0], 5'd0 (rs=$r0), 17'(code)}.
  - Example: button 0 with INT_REG=27 gives 32'h2EC0_0001.
- Issue FSM:
  - IDLE: if the FIFO is non-empty, pop it, register the instruction, and go to ISSUE. Otherwise the output is 0.
  - ISSUE: the output is the registered instruction for exactly one cycle. Load the gap counter with SPACING-2 and go to GAP.
  - GAP: the output is 0. Decrement the counter; at 0 go to IDLE.
- A FIFO push and pop in the same cycle are both permitted; occupancy is unchanged.
- Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values:
  - `interrupt_instruction`=0, `fifo_count`=0, `busy`=0.
  - FSM=IDLE; sync, prev, lvl and pending all 0.
  - Debounce counters 0.
- Latency, debounce compiled out, counted from the first rising edge at which the pin is high:
  - e1: sync1.
  - e2: sync2.
  - e3: pending.
  - e4: FIFO write.
  - e5: FSM pop.
  - The instruction is valid between e5 and e6.
- With debounce compiled in, add DEBOUNCE_CYCLES edges.
- Back-to-back events appear exactly SPACING cycles apart at the output.
- Reset asserted mid-operation: the output goes to 0 immediately (asynchronous). Queued and pending events are discarded.
- A held button yields one event. Release followed by a new press yields another.

## Configuration
- `IRQ_INJECTOR_DEBOUNCE_EN` defined:
  - Each button has a counter of $clog2(DEBOUNCE_CYCLES+1) bits.
  - While `sync` ≠ `lvl` the counter increments; when it reaches DEBOUNCE_CYCLES, `lvl` takes `sync` and the counter clears.
  - When `sync` == `lvl` the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
- Undefined: `lvl` = `sync`, no counters, glitch-sensitive.

## Structure
- Package `irq_pkg`:
  - opcode constant `OP_ADDI`=5'b00101.
  - field widths (opcode 5, reg 5, imm 17).
  - FSM state enum (IDLE, ISSUE, GAP).
  - function building the instruction word from rd and code.
- Sub-module `irq_fifo`: synchronous FIFO, parameterized width/depth, with push/pop/full/empty/count. Same clock and asynchronous reset.

## Test plan
- Debounce off, press button 2 and hold 20 cycles → exactly one cycle of 32'h2EC0_0003 at e5–e6; output 0 otherwise; `busy` drops afterwards.
- Buttons 0, 1 and 3 rise in the same cycle → 32'h2EC0_0001, 32'h2EC0_0002, 32'h2EC0_0004 in that order, spaced 8 cycles apart.
- FIFO_DEPTH=2, four buttons pressed together → `fifo_count` peaks at 2, pending bits hold, all four instructions eventually issue in index order, none lost.
- Debounce on, 10-cycle glitch on button 1 → no injection. A 20-cycle press → one injection DEBOUNCE_CYCLES cycles later than the no-debounce latency.
- Reset asserted during GAP with 2 events queued → the output is immediately 0, `fifo_count`=0. No injections after release until a new press.
